apu_envelope_unit: RTL and testbench
====================================

// Module: apu_envelope_unit
// PURPOSE
//  Volume envelope generator for the APU square/noise channels; directly downstream of SoftCLK.
//  Consumes SoftCLK's quarter-frame strobe and produces the 4-bit channel volume.
//  Holds the $4000/$4004/$400C volume-control fields and the start flag set by $4003/$4007/$400F writes.
//  Also forwards the loop/halt bit to the length counter.
// PARAMETERS
//  VOL_W      4   width of volume / divider period / decay counter (fixed 4 for 2A03 compatibility)
//  DECAY_INIT 15  value loaded into the decay counter on a start event
// PORTS
//  CLK       in   1      sole clock; all state updates on posedge
//  n_RES     in   1      asynchronous active-low reset
//  qframe    in   1      quarter-frame strobe from SoftCLK; one-CLK active-high pulse
//  ctrl_wr   in   1      write strobe for volume-control register ($4000/$4004/$400C)
//  start_wr  in   1      write strobe for length/start register ($4003/$4007/$400F)
//  DB        in   6      data bus bits [5:0] during ctrl_wr
//  env_out   out  VOL_W  channel volume
//  len_halt  out  1      loop/halt bit (DB[5] of last ctrl_wr) for the length counter
// BEHAVIOUR
//  Reset (async, n_RES=0): V=0, const_vol=0, loop=0, start=0, divider=0, decay=0.
//    env_out=0 and len_halt=0 while reset is asserted and after release.
//  ctrl_wr at posedge: V<=DB[3:0], const_vol<=DB[4], loop<=DB[5]; visible on outputs next cycle.
//  start_wr at posedge: start<=1; DB is ignored.
//  qframe at posedge; all decisions use register values from before this edge:
//    start=1 -> start<=0, decay<=DECAY_INIT, divider<=V.
//    else divider!=0 -> divider<=divider-1.
//    else divider==0 -> divider<=V; decay clock fires:
//      decay!=0          -> decay<=decay-1
//      decay==0, loop=1  -> decay<=15 (wrap)
//      decay==0, loop=0  -> hold at 0
//  Divider period is V+1 quarter frames; V=0 clocks decay on every qframe.
//  env_out = const_vol ? V : decay. Combinational from registers; no added latency.
//  len_halt = loop.
//  Simultaneous events at one posedge:
//    start_wr+qframe: qframe uses old start. If old start=0, do the normal divider step.
//      The new start=1 takes effect at the next qframe.
//    ctrl_wr+qframe: the qframe step uses the old V. The new V applies from the next qframe.
//    ctrl_wr+start_wr: both take effect.
//  Between qframe pulses, divider and decay hold.
//  Reset mid-sequence clears all state immediately. The first qframe after release with start=0
//    follows the divider==0 path: reload divider from V, decay holds at 0 (loop=0).
// STRUCTURE
//  Shared package apu_pkg: VOL_W, bit-position constants ENV_V_LSB=0, ENV_CONST_BIT=4,
//    ENV_LOOP_BIT=5, DECAY_INIT.
//  One sub-module: apu_downcnt. VOL_W-bit down counter with synchronous load and
//    async active-low clear; zero flag output.
//  Instantiated twice: divider, and decay (loop-wrap handled by loading 15).
//  Top level holds the control register, start flag and output mux.
// TESTING
//  1) Write ctrl DB=6'h02 (V=2, decay mode), start_wr, 1 qframe
//     -> env_out=15; then every 3 qframes env_out decrements: 14,13,...
//  2) As 1 until decay=0, loop=0; 5 more qframes -> env_out stays 0.
//     Repeat with DB=6'h22 (loop) -> after 0 comes 15.
//  3) DB=6'h1A (const, V=10), start_wr, 20 qframes -> env_out=10 throughout.
//     Then ctrl_wr DB=6'h0A -> env_out switches to decay value next cycle.
//  4) start_wr and qframe on the same edge with start=0, divider=0, decay=5
//     -> decay=4 that edge; next qframe -> decay=15.
//  5) ctrl_wr DB=6'h05 and qframe on the same edge, old V=0, divider=0
//     -> divider reloads 0 (old V); following reload uses 5.
//  6) Pulse n_RES low between clock edges mid-decay (decay=9)
//     -> env_out=0, len_halt=0 immediately.
//     First qframe after release without start -> env_out remains 0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and control-register layout for the APU envelope unit.
package apu_pkg;

  localparam int VOL_W         = 4;
  localparam int CTRL_W        = 6;
  localparam int ENV_V_LSB     = 0;
  localparam int ENV_CONST_BIT = 4;
  localparam int ENV_LOOP_BIT  = 5;

  localparam logic [VOL_W-1:0] DECAY_INIT = 4'd15;
  localparam logic [VOL_W-1:0] DECAY_WRAP = 4'd15;

  typedef struct packed {
    logic             loop;
    logic             const_vol;
    logic [VOL_W-1:0] vol;
  } env_ctrl_t;

  function automatic env_ctrl_t decode_ctrl(input logic [CTRL_W-1:0] db);
    env_ctrl_t c;
    c.vol       = db[ENV_V_LSB +: VOL_W];
    c.const_vol = db[ENV_CONST_BIT];
    c.loop      = db[ENV_LOOP_BIT];
    return c;
  endfunction

endpackage

// File: rtl/apu_downcnt.sv
// Small down counter with synchronous load, decrement enable and zero flag.
module apu_downcnt
  import apu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VOL_W-1:0] load_val,
  input  logic             dec,
  output logic [VOL_W-1:0] count,
  output logic             zero
);

  logic [VOL_W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/apu_envelope_unit.sv
// APU volume envelope: control register, start flag, divider and decay counters, output mux.
module apu_envelope_unit
  import apu_pkg::*;
(
  input  logic              CLK,
  input  logic              n_RES,
  input  logic              qframe,
  input  logic              ctrl_wr,
  input  logic              start_wr,
  input  logic [CTRL_W-1:0] DB,
  output logic [VOL_W-1:0]  env_out,
  output logic              len_halt
);

  env_ctrl_t ctrl_q, ctrl_d;
  logic      start_q, start_d;

  logic             div_zero, decay_zero;
  logic [VOL_W-1:0] div_count, decay_count;
  logic             div_load, div_dec;
  logic             decay_load, decay_dec;
  logic [VOL_W-1:0] decay_load_val;

  // A start_wr on the same edge as a consuming qframe leaves start pending.
  always_comb begin
    ctrl_d  = ctrl_q;
    start_d = start_q;
    if (ctrl_wr) begin
      ctrl_d = decode_ctrl(DB);
    end
    if (qframe && start_q) begin
      start_d = 1'b0;
    end
    if (start_wr) begin
      start_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      ctrl_q  <= '0;
      start_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      start_q <= start_d;
    end
  end

  // All qframe decisions look only at pre-edge register values.
  always_comb begin
    div_load       = qframe && (start_q || div_zero);
    div_dec        = qframe && !start_q && !div_zero;
    decay_load     = qframe && (start_q || (div_zero && decay_zero && ctrl_q.loop));
    decay_dec      = qframe && !start_q && div_zero && !decay_zero;
    decay_load_val = start_q ? DECAY_INIT : DECAY_WRAP;
  end

  apu_downcnt u_divider (
    .clk      (CLK),
    .rst_n    (n_RES),
    .load     (div_load),
    .load_val (ctrl_q.vol),
    .dec      (div_dec),
    .count    (div_count),
    .zero     (div_zero)
  );

  apu_downcnt u_decay (
    .clk      (CLK),
    .rst_n    (n_RES),
    .load     (decay_load),
    .load_val (decay_load_val),
    .dec      (decay_dec),
    .count    (decay_count),
    .zero     (decay_zero)
  );

  // The divider count is internal only; its zero flag is what drives the decay clock.
  logic unused_div;
  assign unused_div = ^div_count;

  assign env_out  = ctrl_q.const_vol ? ctrl_q.vol : decay_count;
  assign len_halt = ctrl_q.loop;

endmodule

// File: tb/tb_apu_envelope_unit.sv
// Self-checking bench for apu_envelope_unit: directed scenarios plus random traffic
// compared against an integer reference model of the envelope rules.
module tb_apu_envelope_unit;

  logic       CLK = 1'b0;
  logic       n_RES = 1'b0;
  logic       qframe = 1'b0;
  logic       ctrl_wr = 1'b0;
  logic       start_wr = 1'b0;
  logic [5:0] DB = '0;
  logic [3:0] env_out;
  logic       len_halt;

  int checks = 0;
  int fails  = 0;

  // Reference model state as plain integers.
  int m_v, m_const, m_loop, m_start, m_div, m_decay;

  apu_envelope_unit dut (
    .CLK      (CLK),
    .n_RES    (n_RES),
    .qframe   (qframe),
    .ctrl_wr  (ctrl_wr),
    .start_wr (start_wr),
    .DB       (DB),
    .env_out  (env_out),
    .len_halt (len_halt)
  );

  always #5 CLK = ~CLK;

  task automatic modelReset();
    m_v = 0; m_const = 0; m_loop = 0; m_start = 0; m_div = 0; m_decay = 0;
  endtask

  task automatic modelClock(input bit c, input bit s, input bit q, input logic [5:0] db);
    int ov, os, od, oe, ol;
    ov = m_v; os = m_start; od = m_div; oe = m_decay; ol = m_loop;
    if (q) begin
      if (os != 0) begin
        m_start = 0;
        m_decay = 15;
        m_div   = ov;
      end else if (od != 0) begin
        m_div = od - 1;
      end else begin
        m_div = ov;
        if (oe != 0) m_decay = oe - 1;
        else if (ol != 0) m_decay = 15;
      end
    end
    if (s) m_start = 1;
    if (c) begin
      m_v     = int'(db[3:0]);
      m_const = int'(db[4]);
      m_loop  = int'(db[5]);
    end
  endtask

  function automatic int modelEnv();
    return (m_const != 0) ? m_v : m_decay;
  endfunction

  task automatic applyStimulus(input bit c, input bit s, input bit q, input logic [5:0] db);
    @(negedge CLK);
    ctrl_wr = c; start_wr = s; qframe = q; DB = db;
    @(posedge CLK);
    modelClock(c, s, q, db);
    #1;
    ctrl_wr = 1'b0; start_wr = 1'b0; qframe = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (env_out === 4'(modelEnv())) else begin
      fails++;
      $error("[TB] FAIL %s env_out=%0d expected=%0d", tag, env_out, modelEnv());
    end
    checks++;
    assert (len_halt === 1'(m_loop)) else begin
      fails++;
      $error("[TB] FAIL %s_halt len_halt=%0b expected=%0b", tag, len_halt, m_loop);
    end
  endtask

  task automatic checkConst(input string tag, input logic [3:0] exp);
    checks++;
    assert (env_out === exp) else begin
      fails++;
      $error("[TB] FAIL %s env_out=%0d expected=%0d", tag, env_out, exp);
    end
  endtask

  task automatic runQframes(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
      checkOutput(tag);
    end
  endtask

  initial begin
    modelReset();
    #3;
    checkOutput("reset_held");
    checkConst("reset_env", 4'd0);
    #10 n_RES = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);
    checkOutput("reset_release");

    // Decay mode, V=2, no loop: each level lasts three quarter frames.
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h02);
    checkOutput("s1_ctrl");
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    checkConst("s1_start", 4'd15);
    runQframes(3, "s1_step");
    checkConst("s1_14", 4'd14);
    runQframes(3, "s1_step");
    checkConst("s1_13", 4'd13);
    runQframes(39, "s1_decay");
    checkConst("s2_zero", 4'd0);
    runQframes(5, "s2_hold");
    checkConst("s2_hold0", 4'd0);

    // Same with loop set: zero wraps back to 15.
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h22);
    checkOutput("s2_loop_ctrl");
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    runQframes(45, "s2_loop_decay");
    checkConst("s2_loop_zero", 4'd0);
    runQframes(3, "s2_wrap");
    checkConst("s2_wrap15", 4'd15);

    // Constant volume ignores the decay counter until switched off.
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h1A);
    runQframes(20, "s3_const");
    checkConst("s3_const10", 4'd10);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h0A);
    checkOutput("s3_to_decay");

    // V=0 so decay moves every qframe; walk it down to 5.
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    runQframes(10, "s4_walk");
    checkConst("s4_at5", 4'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h00);
    checkConst("s4_same_edge", 4'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    checkConst("s4_restart", 4'd15);

    // ctrl_wr with qframe: this reload uses the old V=0, the next one uses 5.
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h05);
    checkConst("s5_old_v", 4'd14);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    checkConst("s5_reload", 4'd13);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    checkConst("s5_new_v", 4'd13);
    checkOutput("s5_model");

    // Asynchronous reset pulse mid-decay.
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h20);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    runQframes(6, "s6_walk");
    checkConst("s6_at9", 4'd9);
    #2 n_RES = 1'b0;
    modelReset();
    #1;
    checkConst("s6_reset_env", 4'd0);
    checkOutput("s6_reset");
    #1 n_RES = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
    checkConst("s6_after", 4'd0);
    checkOutput("s6_after_model");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(7) == 0, $urandom_range(15) == 0,
                    $urandom_range(2) == 0, 6'($urandom));
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
